// File: rtl/line_scan_pkg.sv
// Shared video definitions for the motion-object line buffers.
package line_scan_pkg;

   localparam int unsigned LB_AW = 8;
   localparam int unsigned LB_DW = 8;

   // Transparent pixel; also the value left behind after a scan erases a location.
   localparam logic [LB_DW-1:0] TRANSPARENT = 8'h00;

   typedef enum logic [1:0] {
      StWait,
      StRd,
      StEr,
      StDone
   } scan_state_e;

endpackage

// File: rtl/line_scan.sv
// Read side of the ping-pong motion-object line buffers: scans one pixel per
// pix_en out of the display buffer, hands it to the mixer and erases the
// location behind it. Buffers swap at each line_start.
module line_scan
   import line_scan_pkg::*;
#(
   parameter int unsigned       LINE_LEN  = 256,
   parameter logic [LB_AW-1:0]  X_START   = 8'h00,
   parameter logic [LB_DW-1:0]  ERASE_VAL = TRANSPARENT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_start,
   input  logic              pix_en,
   output logic [LB_AW-1:0]  lb_a,
   output logic              lb_r,
   output logic              lb_w,
   output logic [LB_DW-1:0]  lb_i,
   input  logic [LB_DW-1:0]  lb_o,
   output logic              buf_sel,
   output logic [LB_DW-1:0]  pix_out,
   output logic              pix_valid,
   output logic              overrun
);

   // Wide enough to hold LINE_LEN itself.
   localparam int unsigned CW = $clog2(LINE_LEN + 1);

   scan_state_e      state_q, state_d;
   logic [LB_AW-1:0] x_q, x_d;
   logic [CW-1:0]    count_q, count_d;
   logic             buf_sel_q, buf_sel_d;
   logic             pending_q, pending_d;
   logic [LB_AW-1:0] lb_a_q, lb_a_d;
   logic             lb_r_q, lb_r_d;
   logic             lb_w_q, lb_w_d;
   logic [LB_DW-1:0] pix_out_q, pix_out_d;
   logic             pix_valid_q, pix_valid_d;
   logic             overrun_q, overrun_d;
   logic             do_swap;

   // Next-state logic. Strobes are registered: the read strobe is issued in the
   // cycle after pix_en, the erase one cycle later, and read data (registered by
   // the buffer on the read edge) is captured while the erase strobe is high.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      count_d     = count_q;
      buf_sel_d   = buf_sel_q;
      pending_d   = pending_q;
      lb_a_d      = lb_a_q;
      lb_r_d      = 1'b0;
      lb_w_d      = 1'b0;
      pix_out_d   = pix_out_q;
      pix_valid_d = 1'b0;
      overrun_d   = overrun_q;
      do_swap     = 1'b0;

      unique case (state_q)
         StWait: begin
            if (line_start) begin
               do_swap = 1'b1;
            end else if (pix_en) begin
               lb_a_d  = x_q;
               lb_r_d  = 1'b1;
               state_d = StRd;
            end
         end
         StRd: begin
            // lb_a_q is held so the erase hits the location just read.
            lb_w_d  = 1'b1;
            x_d     = x_q + 8'd1;
            count_d = count_q + CW'(1);
            state_d = StEr;
            if (line_start) pending_d = 1'b1;
            if (pix_en)     overrun_d = 1'b1;
         end
         StEr: begin
            pix_out_d   = lb_o;
            pix_valid_d = 1'b1;
            if (pix_en) overrun_d = 1'b1;
            // A line_start landing here merges with any pending one.
            if (pending_q || line_start) begin
               do_swap   = 1'b1;
               pending_d = 1'b0;
            end else if (count_q == CW'(LINE_LEN)) begin
               state_d = StDone;
            end else begin
               state_d = StWait;
            end
         end
         StDone: begin
            if (line_start) begin
               do_swap = 1'b1;
            end else if (pix_en) begin
               pix_out_d = ERASE_VAL;
            end
         end
         default: state_d = StDone;
      endcase

      if (do_swap) begin
         buf_sel_d = ~buf_sel_q;
         x_d       = X_START;
         count_d   = '0;
         state_d   = StWait;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StDone;
         x_q         <= X_START;
         count_q     <= '0;
         buf_sel_q   <= 1'b0;
         pending_q   <= 1'b0;
         lb_a_q      <= '0;
         lb_r_q      <= 1'b0;
         lb_w_q      <= 1'b0;
         pix_out_q   <= ERASE_VAL;
         pix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         count_q     <= count_d;
         buf_sel_q   <= buf_sel_d;
         pending_q   <= pending_d;
         lb_a_q      <= lb_a_d;
         lb_r_q      <= lb_r_d;
         lb_w_q      <= lb_w_d;
         pix_out_q   <= pix_out_d;
         pix_valid_q <= pix_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign lb_a      = lb_a_q;
   assign lb_r      = lb_r_q;
   assign lb_w      = lb_w_q;
   assign lb_i      = ERASE_VAL;
   assign buf_sel   = buf_sel_q;
   assign pix_out   = pix_out_q;
   assign pix_valid = pix_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_line_scan.sv
// Directed bench for line_scan: dut0 uses the default geometry, dut1 a short
// line starting near the top of the address space so addresses wrap.
module tb_line_scan;
   import line_scan_pkg::*;

   logic clk;
   logic reset;
   logic clr;

   logic       line_start0, pix_en0, lb_r0, lb_w0, buf_sel0, pix_valid0, overrun0;
   logic [7:0] lb_a0, lb_i0, lb_o0, pix_out0;
   logic       line_start1, pix_en1, lb_r1, lb_w1, buf_sel1, pix_valid1, overrun1;
   logic [7:0] lb_a1, lb_i1, lb_o1, pix_out1;

   // Two line buffers per DUT, selected by buf_sel like the parent mux.
   logic [7:0] mem0 [0:1][0:255];
   logic [7:0] mem1 [0:1][0:255];
   int         rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;

   logic       pre_we, pre_dut, pre_buf;
   logic [7:0] pre_addr, pre_data;

   int vectors;
   int miscompares;

   line_scan dut0 (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start0),
      .pix_en     (pix_en0),
      .lb_a       (lb_a0),
      .lb_r       (lb_r0),
      .lb_w       (lb_w0),
      .lb_i       (lb_i0),
      .lb_o       (lb_o0),
      .buf_sel    (buf_sel0),
      .pix_out    (pix_out0),
      .pix_valid  (pix_valid0),
      .overrun    (overrun0)
   );

   line_scan #(
      .LINE_LEN (4),
      .X_START  (8'hFE)
   ) dut1 (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start1),
      .pix_en     (pix_en1),
      .lb_a       (lb_a1),
      .lb_r       (lb_r1),
      .lb_w       (lb_w1),
      .lb_i       (lb_i1),
      .lb_o       (lb_o1),
      .buf_sel    (buf_sel1),
      .pix_out    (pix_out1),
      .pix_valid  (pix_valid1),
      .overrun    (overrun1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer models: registered read on lb_r, write on lb_w, plus bench preload.
   always @(posedge clk) begin
      if (pre_we && !pre_dut) mem0[pre_buf][pre_addr] <= pre_data;
      if (pre_we &&  pre_dut) mem1[pre_buf][pre_addr] <= pre_data;
      if (lb_r0) lb_o0 <= mem0[buf_sel0][lb_a0];
      if (lb_w0) mem0[buf_sel0][lb_a0] <= lb_i0;
      if (lb_r1) lb_o1 <= mem1[buf_sel1][lb_a1];
      if (lb_w1) mem1[buf_sel1][lb_a1] <= lb_i1;
      if (clr) begin
         rd_cnt0 <= 0; wr_cnt0 <= 0; rd_cnt1 <= 0; wr_cnt1 <= 0;
      end else begin
         if (lb_r0) rd_cnt0 <= rd_cnt0 + 1;
         if (lb_w0) wr_cnt0 <= wr_cnt0 + 1;
         if (lb_r1) rd_cnt1 <= rd_cnt1 + 1;
         if (lb_w1) wr_cnt1 <= wr_cnt1 + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic d, input logic b, input logic [7:0] a,
                          input logic [7:0] v);
      pre_dut  = d;
      pre_buf  = b;
      pre_addr = a;
      pre_data = v;
      pre_we   = 1'b1;
      tick();
      pre_we   = 1'b0;
   endtask

   logic [7:0] exp0 [0:3];
   logic [7:0] adr1 [0:3];
   logic [7:0] exp1 [0:3];
   int         rd_before;
   int         wr_before;

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp0 = '{8'h11, 8'h22, 8'h33, 8'h44};
      adr1 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      exp1 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      reset = 1'b1; clr = 1'b1; pre_we = 1'b0; pre_dut = 1'b0; pre_buf = 1'b0;
      pre_addr = 8'h00; pre_data = 8'h00;
      line_start0 = 1'b0; pix_en0 = 1'b0; line_start1 = 1'b0; pix_en1 = 1'b0;
      tick();
      tick();
      reset = 1'b0; clr = 1'b0;

      // Reset state
      chk("rst_state",   32'(dut0.state_q), 32'(StDone));
      chk("rst_buf_sel", 32'(buf_sel0), 32'd0);
      chk("rst_lb_r",    32'(lb_r0), 32'd0);
      chk("rst_lb_w",    32'(lb_w0), 32'd0);
      chk("rst_lb_a",    32'(lb_a0), 32'd0);
      chk("rst_lb_i",    32'(lb_i0), 32'h00);
      chk("rst_pix_out", 32'(pix_out0), 32'h00);
      chk("rst_valid",   32'(pix_valid0), 32'd0);
      chk("rst_overrun", 32'(overrun0), 32'd0);

      // The writer fills the buffer it owns (~buf_sel = 1) before the swap.
      for (int i = 0; i < 4; i++) preload(1'b0, 1'b1, 8'(i), exp0[i]);
      preload(1'b0, 1'b1, 8'h05, 8'h55);
      for (int i = 0; i < 4; i++) preload(1'b1, 1'b1, adr1[i], exp1[i]);

      line_start0 = 1'b1;
      tick();
      line_start0 = 1'b0;
      chk("swap_buf_sel", 32'(buf_sel0), 32'd1);

      // Basic scan: four pixels, 4 clocks apart
      for (int i = 0; i < 4; i++) begin
         pix_en0 = 1'b1;
         tick();
         pix_en0 = 1'b0;
         chk("scan_lb_r", 32'(lb_r0), 32'd1);
         chk("scan_lb_a", 32'(lb_a0), 32'(i));
         tick();
         chk("scan_lb_w",   32'(lb_w0), 32'd1);
         chk("scan_rd_off", 32'(lb_r0), 32'd0);
         chk("scan_early",  32'(pix_valid0), 32'd0);
         tick();
         chk("scan_valid",  32'(pix_valid0), 32'd1);
         chk("scan_pix",    32'(pix_out0), 32'(exp0[i]));
         tick();
         chk("scan_vpulse", 32'(pix_valid0), 32'd0);
      end
      for (int i = 0; i < 4; i++) chk("scan_erased", 32'(mem0[1][i]), 32'h00);

      // Overrun: pix_en one clock after an accepted one
      rd_before = rd_cnt0;
      pix_en0 = 1'b1;
      tick();
      tick();
      pix_en0 = 1'b0;
      tick();
      tick();
      chk("ovr_flag",  32'(overrun0), 32'd1);
      chk("ovr_reads", 32'(rd_cnt0 - rd_before), 32'd1);
      chk("ovr_x",     32'(dut0.x_q), 32'd5);

      // line_start while the read is in flight, repeated during the pending swap
      pix_en0 = 1'b1;
      tick();
      pix_en0 = 1'b0;
      line_start0 = 1'b1;
      tick();
      chk("pend_lb_w",    32'(lb_w0), 32'd1);
      chk("pend_lb_a",    32'(lb_a0), 32'd5);
      chk("pend_old_buf", 32'(buf_sel0), 32'd1);
      tick();
      line_start0 = 1'b0;
      chk("pend_swapped", 32'(buf_sel0), 32'd0);
      chk("pend_x",       32'(dut0.x_q), 32'd0);
      chk("pend_pix",     32'(pix_out0), 32'h55);
      chk("pend_state",   32'(dut0.state_q), 32'(StWait));
      tick();
      chk("pend_single",  32'(buf_sel0), 32'd0);
      chk("pend_erased",  32'(mem0[1][5]), 32'h00);

      // Reset while a read is in flight
      line_start0 = 1'b1;
      tick();
      line_start0 = 1'b0;
      pix_en0 = 1'b1;
      tick();
      pix_en0 = 1'b0;
      chk("rrd_lb_r", 32'(lb_r0), 32'd1);
      wr_before = wr_cnt0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rrd_lb_r0",    32'(lb_r0), 32'd0);
      chk("rrd_lb_w0",    32'(lb_w0), 32'd0);
      chk("rrd_buf_sel",  32'(buf_sel0), 32'd0);
      chk("rrd_pix_out",  32'(pix_out0), 32'h00);
      chk("rrd_overrun",  32'(overrun0), 32'd0);
      chk("rrd_state",    32'(dut0.state_q), 32'(StDone));
      tick();
      chk("rrd_no_erase", 32'(wr_cnt0 - wr_before), 32'd0);

      // Short line with wrapping addresses; extra pix_en land in DONE
      rd_before = rd_cnt1;
      wr_before = wr_cnt1;
      line_start1 = 1'b1;
      tick();
      line_start1 = 1'b0;
      chk("wrap_buf_sel", 32'(buf_sel1), 32'd1);
      for (int i = 0; i < 6; i++) begin
         pix_en1 = 1'b1;
         tick();
         pix_en1 = 1'b0;
         if (i < 4) begin
            chk("wrap_lb_r", 32'(lb_r1), 32'd1);
            chk("wrap_lb_a", 32'(lb_a1), 32'(adr1[i]));
            tick();
            tick();
            chk("wrap_pix",  32'(pix_out1), 32'(exp1[i]));
         end else begin
            chk("done_no_rd", 32'(lb_r1), 32'd0);
            chk("done_pix",   32'(pix_out1), 32'h00);
            tick();
            tick();
         end
         tick();
      end
      chk("wrap_reads",   32'(rd_cnt1 - rd_before), 32'd4);
      chk("wrap_erases",  32'(wr_cnt1 - wr_before), 32'd4);
      chk("wrap_state",   32'(dut1.state_q), 32'(StDone));
      chk("wrap_overrun", 32'(overrun1), 32'd0);
      for (int i = 0; i < 4; i++) chk("wrap_erased", 32'(mem1[1][adr1[i]]), 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
